// File: rtl/piso_rr_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter feeding the PISO.
package piso_rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/piso_rr_arb_if.sv
// Requester-side and PISO-side handshake bundle of piso_rr_arb.
interface piso_rr_arb_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IDX_WIDTH  = 2,
    parameter int unsigned CNT_WIDTH  = 16
);

    logic [NUM_REQ-1:0]            CFG_MASK;
    logic [NUM_REQ-1:0]            REQ_VLD;
    logic [NUM_REQ-1:0]            REQ_LAST;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DAT;
    logic [NUM_REQ-1:0]            REQ_RDY;
    logic                          OUT_VLD;
    logic                          OUT_LAST;
    logic [DATA_WIDTH-1:0]         OUT_DAT;
    logic [IDX_WIDTH-1:0]          OUT_IDX;
    logic                          OUT_RDY;
    logic                          BUSY;
    logic                          PKT_DONE;
    logic [IDX_WIDTH-1:0]          PKT_IDX;
    logic [CNT_WIDTH-1:0]          PKT_BEATS;

    modport slave (
        input  CFG_MASK, REQ_VLD, REQ_LAST, REQ_DAT, OUT_RDY,
        output REQ_RDY, OUT_VLD, OUT_LAST, OUT_DAT, OUT_IDX,
               BUSY, PKT_DONE, PKT_IDX, PKT_BEATS
    );

    modport master (
        output CFG_MASK, REQ_VLD, REQ_LAST, REQ_DAT, OUT_RDY,
        input  REQ_RDY, OUT_VLD, OUT_LAST, OUT_DAT, OUT_IDX,
               BUSY, PKT_DONE, PKT_IDX, PKT_BEATS
    );

endinterface

// File: rtl/piso_rr_arb_rr_pick.sv
// Combinational round-robin pick: first set request bit after ptr, wrapping modulo NUM_REQ.
module rr_pick
    import piso_rr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = clog2_f(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 found
);

    logic [IDX_WIDTH-1:0] pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            pos = IDX_WIDTH'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/piso_rr_arb.sv
// Packet-level round-robin arbiter: locks one requester per packet and forwards it to the PISO.
module piso_rr_arb
    import piso_rr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IDX_WIDTH  = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic          CLK,
    input  logic          RST,
    piso_rr_arb_if.slave  bus
);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("piso_rr_arb: NUM_REQ must be at least 2");
    end
    if (IDX_WIDTH != clog2_f(NUM_REQ)) begin : g_bad_idx_width
        $error("piso_rr_arb: IDX_WIDTH must equal clog2(NUM_REQ)");
    end

    arb_state_e             state_q, state_d;
    logic [IDX_WIDTH-1:0]   grant_q, grant_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic                   pkt_done_q, pkt_done_d;
    logic [IDX_WIDTH-1:0]   pkt_idx_q, pkt_idx_d;
    logic [CNT_WIDTH-1:0]   pkt_beats_q, pkt_beats_d;

    logic [NUM_REQ-1:0]     cand;
    logic [IDX_WIDTH-1:0]   win_idx;
    logic                   win_found;
    logic                   locked;
    logic                   sel_vld;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_dat;
    logic [NUM_REQ-1:0]     rdy_vec;
    logic                   hs;
    logic [CNT_WIDTH-1:0]   beat_inc;

    // Mask is only consulted here, so clearing it mid-packet cannot abort the lock.
    assign cand = bus.REQ_VLD & bus.CFG_MASK;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req   (cand),
        .ptr   (ptr_q),
        .idx   (win_idx),
        .found (win_found)
    );

    always_comb begin
        locked   = (state_q == LOCK);
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = '0;
        rdy_vec  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_WIDTH'(i)) begin
                sel_vld    = bus.REQ_VLD[i];
                sel_last   = bus.REQ_LAST[i];
                sel_dat    = bus.REQ_DAT[i*DATA_WIDTH +: DATA_WIDTH];
                rdy_vec[i] = locked & bus.OUT_RDY;
            end
        end
        hs       = locked & sel_vld & bus.OUT_RDY;
        beat_inc = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
    end

    assign bus.REQ_RDY   = rdy_vec;
    assign bus.OUT_VLD   = locked & sel_vld;
    assign bus.OUT_LAST  = locked & sel_last;
    assign bus.OUT_DAT   = locked ? sel_dat : '0;
    assign bus.OUT_IDX   = locked ? grant_q : '0;
    assign bus.BUSY      = locked;
    assign bus.PKT_DONE  = pkt_done_q;
    assign bus.PKT_IDX   = pkt_idx_q;
    assign bus.PKT_BEATS = pkt_beats_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_done_d  = 1'b0;
        pkt_idx_d   = pkt_idx_q;
        pkt_beats_d = pkt_beats_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d    = win_idx;
                    state_d    = LOCK;
                    beat_cnt_d = '0;
                end
            end
            LOCK: begin
                if (hs) begin
                    beat_cnt_d = beat_inc;
                    if (sel_last) begin
                        state_d     = IDLE;
                        ptr_d       = grant_q;
                        pkt_done_d  = 1'b1;
                        pkt_idx_d   = grant_q;
                        pkt_beats_d = beat_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= IDX_WIDTH'(NUM_REQ - 1);
            beat_cnt_q  <= '0;
            pkt_done_q  <= 1'b0;
            pkt_idx_q   <= '0;
            pkt_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_done_q  <= pkt_done_d;
            pkt_idx_q   <= pkt_idx_d;
            pkt_beats_q <= pkt_beats_d;
        end
    end

endmodule

// File: tb/tb_piso_rr_arb.sv
// Directed self-checking bench for piso_rr_arb; inputs change 1ns after posedge, outputs sampled at negedge.
module tb_piso_rr_arb;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int IW = 2;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    piso_rr_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

    piso_rr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] word(input int r, input int w);
        return {16'hC0DE, 16'(r), 16'(w), 16'h5A5A};
    endfunction

    task automatic set_word(input int r, input int w);
        bus.REQ_DAT[r*DW +: DW] = word(r, w);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.REQ_VLD  = '0;
        bus.REQ_LAST = '0;
        bus.OUT_RDY  = 1'b1;
        bus.CFG_MASK = '1;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [8:0] got9;
        rst = 1'b1;
        bus.CFG_MASK = '1;
        bus.REQ_VLD  = 4'b1111;
        bus.REQ_LAST = 4'b1111;
        bus.REQ_DAT  = '1;
        bus.OUT_RDY  = 1'b1;
        tick;
        tick;
        @(negedge clk);
        got9 = {bus.BUSY, bus.OUT_VLD, bus.OUT_LAST, bus.OUT_IDX, bus.REQ_RDY};
        n_checks++;
        if (got9 !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected %b", got9, 9'b0);
        end
        n_checks++;
        if (bus.OUT_DAT !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_dat: got %h expected 0", bus.OUT_DAT);
        end
        n_checks++;
        if ({bus.PKT_DONE, bus.PKT_IDX, bus.PKT_BEATS} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_pkt: got %b/%0d/%0d expected 0/0/0", bus.PKT_DONE, bus.PKT_IDX, bus.PKT_BEATS);
        end
        tick;
        rst = 1'b0;
        bus.REQ_VLD = '0;
    endtask

    task automatic test_single_packet;
        logic [8:0] got9, exp9;
        do_reset;
        bus.REQ_VLD = 4'b0001;
        set_word(0, 0);
        @(negedge clk);
        n_checks++;
        if ({bus.BUSY, bus.OUT_VLD, bus.REQ_RDY} !== 6'b0) begin
            n_fail++;
            $display("FAIL sp_bubble: got %b expected %b", {bus.BUSY, bus.OUT_VLD, bus.REQ_RDY}, 6'b0);
        end
        tick;
        for (int w = 0; w < 3; w++) begin
            set_word(0, w);
            bus.REQ_LAST[0] = (w == 2);
            @(negedge clk);
            got9 = {bus.BUSY, bus.OUT_VLD, bus.OUT_LAST, bus.OUT_IDX, bus.REQ_RDY};
            exp9 = {1'b1, 1'b1, (w == 2), 2'd0, 4'b0001};
            n_checks++;
            if (got9 !== exp9) begin
                n_fail++;
                $display("FAIL sp_word%0d_ctl: got %b expected %b", w, got9, exp9);
            end
            n_checks++;
            if (bus.OUT_DAT !== word(0, w)) begin
                n_fail++;
                $display("FAIL sp_word%0d_dat: got %h expected %h", w, bus.OUT_DAT, word(0, w));
            end
            n_checks++;
            if (bus.PKT_DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL sp_early_done%0d: got %b expected 0", w, bus.PKT_DONE);
            end
            tick;
        end
        bus.REQ_VLD  = '0;
        bus.REQ_LAST = '0;
        @(negedge clk);
        n_checks++;
        if ({bus.PKT_DONE, bus.PKT_IDX, bus.PKT_BEATS, bus.BUSY} !== {1'b1, 2'd0, 16'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL sp_done: got %b/%0d/%0d/%b expected 1/0/3/0", bus.PKT_DONE, bus.PKT_IDX, bus.PKT_BEATS, bus.BUSY);
        end
        tick;
        @(negedge clk);
        n_checks++;
        if ({bus.PKT_DONE, bus.PKT_BEATS} !== {1'b0, 16'd3}) begin
            n_fail++;
            $display("FAIL sp_hold: got %b/%0d expected 0/3", bus.PKT_DONE, bus.PKT_BEATS);
        end
        tick;
    endtask

    task automatic test_round_robin;
        logic [8:0] got9, exp9;
        do_reset;
        bus.REQ_VLD  = 4'b1111;
        bus.REQ_LAST = 4'b1111;
        for (int r = 0; r < NR; r++) set_word(r, 7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.BUSY, bus.OUT_VLD, bus.REQ_RDY} !== 6'b0) begin
                n_fail++;
                $display("FAIL rr_idle%0d: got %b expected %b", k, {bus.BUSY, bus.OUT_VLD, bus.REQ_RDY}, 6'b0);
            end
            if (k > 0) begin
                n_checks++;
                if ({bus.PKT_DONE, bus.PKT_IDX, bus.PKT_BEATS} !== {1'b1, IW'((k - 1) % 4), 16'd1}) begin
                    n_fail++;
                    $display("FAIL rr_done%0d: got %b/%0d/%0d expected 1/%0d/1", k, bus.PKT_DONE, bus.PKT_IDX, bus.PKT_BEATS, (k - 1) % 4);
                end
            end
            tick;
            @(negedge clk);
            got9 = {bus.BUSY, bus.OUT_VLD, bus.OUT_LAST, bus.OUT_IDX, bus.REQ_RDY};
            exp9 = {1'b1, 1'b1, 1'b1, IW'(k % 4), 4'(1 << (k % 4))};
            n_checks++;
            if (got9 !== exp9) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b expected %b", k, got9, exp9);
            end
            n_checks++;
            if (bus.OUT_DAT !== word(k % 4, 7)) begin
                n_fail++;
                $display("FAIL rr_dat%0d: got %h expected %h", k, bus.OUT_DAT, word(k % 4, 7));
            end
            tick;
        end
        bus.REQ_VLD = '0;
        tick;
    endtask

    task automatic test_stall;
        logic [7:0] got8, exp8;
        do_reset;
        bus.REQ_VLD = 4'b0110;
        set_word(1, 0);
        set_word(2, 0);
        @(negedge clk);
        tick;
        @(negedge clk);
        got8 = {bus.BUSY, bus.OUT_VLD, bus.OUT_IDX, bus.REQ_RDY};
        n_checks++;
        if (got8 !== 8'b1_1_01_0010) begin
            n_fail++;
            $display("FAIL st_first: got %b expected %b", got8, 8'b1_1_01_0010);
        end
        tick;
        bus.REQ_VLD = 4'b0100;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            got8 = {bus.BUSY, bus.OUT_VLD, bus.OUT_IDX, bus.REQ_RDY};
            exp8 = 8'b1_0_01_0010;
            n_checks++;
            if (got8 !== exp8) begin
                n_fail++;
                $display("FAIL st_gap%0d: got %b expected %b", g, got8, exp8);
            end
            tick;
        end
        bus.REQ_VLD  = 4'b0110;
        bus.REQ_LAST = 4'b0010;
        set_word(1, 1);
        @(negedge clk);
        n_checks++;
        if ({bus.BUSY, bus.OUT_VLD, bus.OUT_LAST, bus.OUT_IDX, bus.OUT_DAT} !== {3'b111, 2'd1, word(1, 1)}) begin
            n_fail++;
            $display("FAIL st_last: got %b%b%b/%0d/%h expected 111/1/%h", bus.BUSY, bus.OUT_VLD, bus.OUT_LAST, bus.OUT_IDX, bus.OUT_DAT, word(1, 1));
        end
        tick;
        bus.REQ_VLD  = 4'b0100;
        bus.REQ_LAST = '0;
        @(negedge clk);
        n_checks++;
        if ({bus.PKT_DONE, bus.PKT_IDX, bus.PKT_BEATS, bus.BUSY} !== {1'b1, 2'd1, 16'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL st_done: got %b/%0d/%0d/%b expected 1/1/2/0", bus.PKT_DONE, bus.PKT_IDX, bus.PKT_BEATS, bus.BUSY);
        end
        tick;
        @(negedge clk);
        n_checks++;
        if ({bus.BUSY, bus.OUT_IDX} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL st_next: got %b/%0d expected 1/2", bus.BUSY, bus.OUT_IDX);
        end
        bus.REQ_VLD = '0;
        tick;
    endtask

    task automatic test_mask;
        int exp_seq[6] = '{0, 1, 3, 0, 1, 3};
        do_reset;
        bus.CFG_MASK = 4'b1011;
        bus.REQ_VLD  = 4'b1111;
        bus.REQ_LAST = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick;
            @(negedge clk);
            n_checks++;
            if ({bus.BUSY, bus.OUT_IDX} !== {1'b1, IW'(exp_seq[k])}) begin
                n_fail++;
                $display("FAIL mk_grant%0d: got %b/%0d expected 1/%0d", k, bus.BUSY, bus.OUT_IDX, exp_seq[k]);
            end
            tick;
        end
        bus.CFG_MASK = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.BUSY, bus.OUT_VLD, bus.REQ_RDY} !== 6'b0) begin
                n_fail++;
                $display("FAIL mk_zero%0d: got %b expected %b", k, {bus.BUSY, bus.OUT_VLD, bus.REQ_RDY}, 6'b0);
            end
            tick;
        end
        do_reset;
        bus.REQ_VLD = 4'b0001;
        set_word(0, 3);
        tick;
        bus.CFG_MASK = 4'b0000;
        @(negedge clk);
        n_checks++;
        if ({bus.BUSY, bus.OUT_VLD, bus.OUT_IDX} !== {2'b11, 2'd0}) begin
            n_fail++;
            $display("FAIL mk_clear_mid: got %b%b/%0d expected 11/0", bus.BUSY, bus.OUT_VLD, bus.OUT_IDX);
        end
        tick;
        bus.REQ_LAST = 4'b0001;
        tick;
        bus.REQ_VLD  = '0;
        bus.REQ_LAST = '0;
        @(negedge clk);
        n_checks++;
        if ({bus.PKT_DONE, bus.PKT_IDX, bus.PKT_BEATS} !== {1'b1, 2'd0, 16'd2}) begin
            n_fail++;
            $display("FAIL mk_clear_done: got %b/%0d/%0d expected 1/0/2", bus.PKT_DONE, bus.PKT_IDX, bus.PKT_BEATS);
        end
        tick;
    endtask

    task automatic test_out_rdy;
        int hs_cnt = 0;
        do_reset;
        bus.REQ_VLD = 4'b0001;
        set_word(0, 0);
        tick;
        for (int w = 0; w < 4; w++) begin
            set_word(0, w);
            bus.REQ_LAST[0] = (w == 3);
            bus.OUT_RDY = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({bus.BUSY, bus.OUT_VLD, bus.OUT_LAST, bus.REQ_RDY, bus.OUT_DAT} !== {2'b11, (w == 3), 4'b0000, word(0, w)}) begin
                n_fail++;
                $display("FAIL or_hold%0d: got %b%b%b/%b/%h expected 11%b/0000/%h", w, bus.BUSY, bus.OUT_VLD, bus.OUT_LAST, bus.REQ_RDY, bus.OUT_DAT, (w == 3), word(0, w));
            end
            if (bus.OUT_VLD && bus.OUT_RDY) hs_cnt++;
            tick;
            bus.OUT_RDY = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({bus.REQ_RDY, bus.OUT_DAT, bus.PKT_DONE} !== {4'b0001, word(0, w), 1'b0}) begin
                n_fail++;
                $display("FAIL or_take%0d: got %b/%h/%b expected 0001/%h/0", w, bus.REQ_RDY, bus.OUT_DAT, bus.PKT_DONE, word(0, w));
            end
            if (bus.OUT_VLD && bus.OUT_RDY) hs_cnt++;
            tick;
        end
        bus.REQ_VLD  = '0;
        bus.REQ_LAST = '0;
        @(negedge clk);
        n_checks++;
        if (hs_cnt !== 4) begin
            n_fail++;
            $display("FAIL or_hs_count: got %0d expected 4", hs_cnt);
        end
        n_checks++;
        if ({bus.PKT_DONE, bus.PKT_BEATS} !== {1'b1, 16'd4}) begin
            n_fail++;
            $display("FAIL or_done: got %b/%0d expected 1/4", bus.PKT_DONE, bus.PKT_BEATS);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        do_reset;
        bus.REQ_VLD  = 4'b0010;
        bus.REQ_LAST = 4'b0010;
        tick;
        tick;
        bus.REQ_VLD  = 4'b0100;
        bus.REQ_LAST = '0;
        set_word(2, 0);
        tick;
        @(negedge clk);
        n_checks++;
        if ({bus.BUSY, bus.OUT_IDX} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL rm_grant: got %b/%0d expected 1/2", bus.BUSY, bus.OUT_IDX);
        end
        tick;
        set_word(2, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.REQ_VLD = 4'b0111;
        @(negedge clk);
        n_checks++;
        if ({bus.BUSY, bus.OUT_VLD, bus.REQ_RDY, bus.PKT_DONE, bus.PKT_BEATS} !== {7'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL rm_after: got %b%b/%b/%b/%0d expected 00/0000/0/0", bus.BUSY, bus.OUT_VLD, bus.REQ_RDY, bus.PKT_DONE, bus.PKT_BEATS);
        end
        tick;
        @(negedge clk);
        n_checks++;
        if ({bus.BUSY, bus.OUT_IDX} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL rm_rearb: got %b/%0d expected 1/0", bus.BUSY, bus.OUT_IDX);
        end
        bus.REQ_VLD = '0;
        tick;
    endtask

    initial begin
        bus.CFG_MASK = '1;
        bus.REQ_VLD  = '0;
        bus.REQ_LAST = '0;
        bus.REQ_DAT  = '0;
        bus.OUT_RDY  = 1'b1;
        test_reset;
        test_single_packet;
        test_round_robin;
        test_stall;
        test_mask;
        test_out_rdy;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_rr_arb.md
Name: piso_rr_arb

Overview:
- N-way packet-level round-robin arbiter in front of one shared PISO serializer. The PISO narrows wide words to the DRAM/off-chip bus width.
- Several producers (e.g. per-core result writers) each present DATA_WIDTH words framed by LAST.
- The arbiter locks one requester for a whole packet and forwards it word by word to the PISO input. It tags each forwarded word with the owner index.
- It reports per-packet completion and beat count to the top-level controller.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DATA_WIDTH, 64, requester word width; equals the PISO input width
- IDX_WIDTH, 2, width of requester index; equals clog2(NUM_REQ)
- CNT_WIDTH, 16, width of per-packet beat counter

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- CFG_MASK  in  NUM_REQ  per-requester enable; bit=0 excludes that requester from arbitration
- REQ_VLD  in  NUM_REQ  per-requester word valid
- REQ_LAST  in  NUM_REQ  per-requester last word of packet
- REQ_DAT  in  NUM_REQ*DATA_WIDTH  packed words; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- REQ_RDY  out  NUM_REQ  per-requester ready
- OUT_VLD  out  1  word valid toward PISO IN_VLD
- OUT_LAST  out  1  toward PISO IN_LAST
- OUT_DAT  out  DATA_WIDTH  toward PISO IN_DAT
- OUT_IDX  out  IDX_WIDTH  owner of current word
- OUT_RDY  in  1  from PISO IN_RDY
- BUSY  out  1  packet locked
- PKT_DONE  out  1  one-cycle pulse after packet completes
- PKT_IDX  out  IDX_WIDTH  owner of completed packet
- PKT_BEATS  out  CNT_WIDTH  word count of completed packet

Behaviour:
- One clock CLK. RST is synchronous and active-high: sampled on the CLK rising edge, with no asynchronous path.
- States: IDLE, LOCK.
- Reset values:
  - state=IDLE, grant=0, ptr=NUM_REQ-1, so requester 0 has first priority.
  - beat_cnt=0, BUSY=0, REQ_RDY=0, OUT_VLD=0, OUT_LAST=0, OUT_IDX=0, OUT_DAT=0.
  - PKT_DONE=0, PKT_IDX=0, PKT_BEATS=0.
- IDLE:
  - cand = REQ_VLD & CFG_MASK.
  - If cand != 0, the winner is the first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - Next cycle: grant <= winner, state <= LOCK, beat_cnt <= 0.
  - In IDLE, OUT_VLD=0 and all REQ_RDY=0. Arbitration costs exactly one bubble cycle per packet.
- LOCK:
  - OUT_VLD=REQ_VLD[grant], OUT_LAST=REQ_LAST[grant], OUT_DAT=REQ_DAT slice of grant, OUT_IDX=grant. All combinational.
  - REQ_RDY[grant]=OUT_RDY; all other REQ_RDY=0.
  - BUSY=1.
  - Each handshake (OUT_VLD&OUT_RDY) increments beat_cnt; it saturates at all-ones and does not wrap.
  - Handshake with OUT_LAST=1:
    - state <= IDLE, ptr <= grant.
    - PKT_DONE <= 1 for one cycle, PKT_IDX <= grant.
    - PKT_BEATS <= beat_cnt+1, saturated.
- Lock holds for the whole packet:
  - Gaps where REQ_VLD[grant]=0 stall the output; there is no timeout.
  - Other requesters are never served mid-packet.
- CFG_MASK is sampled only in IDLE. Clearing a bit for the granted requester mid-packet does not abort the packet.
- Single-word packet (VLD&LAST in the first LOCK cycle) completes in one LOCK cycle; PKT_BEATS=1.
- OUT_RDY=0 holds all outputs and state; beat_cnt is unchanged.
- PKT_IDX and PKT_BEATS hold their values until the next completion.
- RST asserted mid-packet: next cycle is IDLE with reset values. The partially forwarded packet is abandoned, and the PISO must be reset together with this block.
- CFG_MASK=0: stays IDLE indefinitely.
- A requester must hold VLD/DAT/LAST stable until RDY (AXI-stream rule). The block does not check this.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, LOCK=1'b1) and a clog2 function for IDX_WIDTH checks.
- One natural sub-module: rr_pick. It is combinational: NUM_REQ request vector plus ptr gives winner index and a found flag. It is reusable by other arbiters in the design.
- The FSM, counters and mux live in piso_rr_arb.

Test Plan:
- Reset, then REQ_VLD=4'b0001, 3-word packet, OUT_RDY=1:
  - 1 bubble cycle, then OUT_VLD high 3 cycles with OUT_IDX=0.
  - PKT_DONE pulse with PKT_IDX=0, PKT_BEATS=3.
- All four requesters continuously valid, 1-word packets:
  - Grant order 0,1,2,3,0 with one IDLE cycle between packets.
  - REQ_RDY one-hot on the granted bit only.
- Requester 1 mid-packet drops VLD for 5 cycles while requester 2 is valid:
  - OUT_VLD=0 for those 5 cycles, no switch to 2.
  - Packet completes with PKT_BEATS equal to the words sent.
- CFG_MASK=4'b1011, all valid: requester 2 is never granted. Clear bit 0 during requester 0's packet: that packet still completes.
- OUT_RDY toggled 1,0,1,0 under a 4-word packet: each word is held while OUT_RDY=0, and exactly 4 handshakes occur with PKT_BEATS=4.
- RST asserted on word 2 of a 4-word packet: next cycle BUSY=0, REQ_RDY=0, ptr reset, and requester 0 wins the next arbitration.
